if_id_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC register and the IF/ID pipeline register.

---
 rtl/if_id_fetch_stage_if.sv | 39 +++
 rtl/if_id_fetch_stage.sv | 132 +++++++++++++
 tb/tb_if_id_fetch_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_stage_if.sv
// Interface bundling the fetch-stage control inputs, redirect inputs,
// instruction-memory data and the IF/ID register outputs.
// The master side drives the stage (hazard unit, decode, instruction memory);
// the slave side is the fetch stage itself.
interface if_id_fetch_stage_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 PC_Stall;
    logic                 IF_ID_Stall;
    logic                 IF_ID_Flush;
    logic [1:0]           PCSrc;
    logic [31:0]          BranchTarget;
    logic [31:0]          JR_Target;
    logic [31:0]          Instr_In;
    logic [31:0]          PC_Out;
    logic [31:0]          IF_ID_Instr;
    logic [31:0]          IF_ID_PC4;
    logic                 IF_ID_Valid;
    logic [5:0]           IF_ID_OP;
    logic [5:0]           IF_ID_Funct;
    logic [4:0]           IF_ID_RS;
    logic [4:0]           IF_ID_RT;
    logic [4:0]           IF_ID_RD;
    logic                 IF_ID_invalidRt;
    logic [CNT_WIDTH-1:0] StallCount;
    logic [CNT_WIDTH-1:0] FlushCount;

    modport master (
        output PC_Stall, IF_ID_Stall, IF_ID_Flush, PCSrc, BranchTarget, JR_Target, Instr_In,
        input  PC_Out, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, IF_ID_OP, IF_ID_Funct,
               IF_ID_RS, IF_ID_RT, IF_ID_RD, IF_ID_invalidRt, StallCount, FlushCount
    );

    modport slave (
        input  PC_Stall, IF_ID_Stall, IF_ID_Flush, PCSrc, BranchTarget, JR_Target, Instr_In,
        output PC_Out, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, IF_ID_OP, IF_ID_Funct,
               IF_ID_RS, IF_ID_RT, IF_ID_RD, IF_ID_invalidRt, StallCount, FlushCount
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, and
// saturating stall/flush event counters for performance debug.
// All outputs come straight from registers; nothing from Instr_In reaches
// an output combinationally.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    if_id_fetch_stage_if.slave  bus
);

    // rt is a source operand only for R-type, BEQ, BNE and SW.
    function automatic logic calc_invalid_rt(input logic [5:0] op);
        logic res;
        case (op)
            6'b000000: res = 1'b0;
            6'b000100: res = 1'b0;
            6'b000101: res = 1'b0;
            6'b101011: res = 1'b0;
            default:   res = 1'b1;
        endcase
        return res;
    endfunction

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]          pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          pc4_q, pc4_d;
    logic                 valid_q, valid_d;
    logic                 invalid_rt_q, invalid_rt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]          pc_plus4_s;
    logic [31:0]          pc_target_s;

    // Next PC: select redirect source, force word alignment, honour PC_Stall.
    always_comb begin
        pc_plus4_s  = pc_q + 32'd4;
        pc_target_s = pc_plus4_s;
        case (bus.PCSrc)
            2'b00:   pc_target_s = pc_plus4_s;
            2'b01:   pc_target_s = bus.BranchTarget;
            2'b10:   pc_target_s = {pc4_q[31:28], instr_q[25:0], 2'b00};
            2'b11:   pc_target_s = bus.JR_Target;
            default: pc_target_s = pc_plus4_s;
        endcase
        if (bus.PC_Stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = {pc_target_s[31:2], 2'b00};
        end
    end

    // IF/ID next state: stall holds (and masks flush), flush inserts a bubble, else load.
    always_comb begin
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        invalid_rt_d = invalid_rt_q;
        if (bus.IF_ID_Stall) begin
            instr_d      = instr_q;
            pc4_d        = pc4_q;
            valid_d      = valid_q;
            invalid_rt_d = invalid_rt_q;
        end else if (bus.IF_ID_Flush) begin
            instr_d      = 32'h0000_0000;
            pc4_d        = 32'h0000_0000;
            valid_d      = 1'b0;
            invalid_rt_d = 1'b0;
        end else begin
            instr_d      = bus.Instr_In;
            pc4_d        = pc_plus4_s;
            valid_d      = 1'b1;
            invalid_rt_d = calc_invalid_rt(bus.Instr_In[31:26]);
        end
    end

    // Saturating event counters; a flush masked by a stall is not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.IF_ID_Stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (bus.IF_ID_Flush && !bus.IF_ID_Stall && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0000_0000;
            pc4_q        <= 32'h0000_0000;
            valid_q      <= 1'b0;
            invalid_rt_q <= 1'b0;
            stall_cnt_q  <= {CNT_WIDTH{1'b0}};
            flush_cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            invalid_rt_q <= invalid_rt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.PC_Out          = pc_q;
    assign bus.IF_ID_Instr     = instr_q;
    assign bus.IF_ID_PC4       = pc4_q;
    assign bus.IF_ID_Valid     = valid_q;
    assign bus.IF_ID_OP        = instr_q[31:26];
    assign bus.IF_ID_Funct     = instr_q[5:0];
    assign bus.IF_ID_RS        = instr_q[25:21];
    assign bus.IF_ID_RT        = instr_q[20:16];
    assign bus.IF_ID_RD        = instr_q[15:11];
    assign bus.IF_ID_invalidRt = invalid_rt_q;
    assign bus.StallCount      = stall_cnt_q;
    assign bus.FlushCount      = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic, then stall-counter saturation; every
// cycle the DUT is compared with a behavioural model of the fetch stage.
module tb_if_id_fetch_stage;

    localparam int CW = 16;

    logic CLK;
    logic RESET_N;

    if_id_fetch_stage_if #(.CNT_WIDTH(CW)) bus ();

    if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_inv;
    int          m_sc, m_fc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the currently driven inputs.
    task automatic model_step();
        logic [31:0] tgt;
        logic [5:0]  op;
        int          cmax;
        cmax = (1 << CW) - 1;
        if (!RESET_N) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_inv = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            if (bus.PCSrc == 2'd0)      tgt = m_pc + 32'd4;
            else if (bus.PCSrc == 2'd1) tgt = bus.BranchTarget;
            else if (bus.PCSrc == 2'd2) tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            else                        tgt = bus.JR_Target;
            tgt = tgt & 32'hFFFF_FFFC;
            if (bus.IF_ID_Stall) begin
                if (m_sc < cmax) m_sc = m_sc + 1;
            end else if (bus.IF_ID_Flush) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_inv = 1'b0;
                if (m_fc < cmax) m_fc = m_fc + 1;
            end else begin
                op      = bus.Instr_In >> 26;
                m_instr = bus.Instr_In;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_inv   = !(op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43);
            end
            if (!bus.PC_Stall) m_pc = tgt;
        end
    endtask

    task automatic compare_model();
        check("PC_Out",      bus.PC_Out,          m_pc);
        check("IF_ID_Instr", bus.IF_ID_Instr,     m_instr);
        check("IF_ID_PC4",   bus.IF_ID_PC4,       m_pc4);
        check("IF_ID_Valid", {31'd0, bus.IF_ID_Valid}, {31'd0, m_valid});
        check("IF_ID_OP",    {26'd0, bus.IF_ID_OP},    m_instr >> 26);
        check("IF_ID_Funct", {26'd0, bus.IF_ID_Funct}, m_instr & 32'h3F);
        check("IF_ID_RS",    {27'd0, bus.IF_ID_RS},    (m_instr >> 21) & 32'h1F);
        check("IF_ID_RT",    {27'd0, bus.IF_ID_RT},    (m_instr >> 16) & 32'h1F);
        check("IF_ID_RD",    {27'd0, bus.IF_ID_RD},    (m_instr >> 11) & 32'h1F);
        check("invalidRt",   {31'd0, bus.IF_ID_invalidRt}, {31'd0, m_inv});
        check("StallCount",  {16'd0, bus.StallCount},  m_sc);
        check("FlushCount",  {16'd0, bus.FlushCount},  m_fc);
    endtask

    // One clock: DUT and model both take the edge, then compare at the falling edge.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_model();
    endtask

    task automatic drive(input logic rst_n, input logic pcs, input logic ids, input logic fl,
                         input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jr,
                         input logic [31:0] ins);
        RESET_N          = rst_n;
        bus.PC_Stall     = pcs;
        bus.IF_ID_Stall  = ids;
        bus.IF_ID_Flush  = fl;
        bus.PCSrc        = src;
        bus.BranchTarget = bt;
        bus.JR_Target    = jr;
        bus.Instr_In     = ins;
    endtask

    initial begin
        logic [5:0]  op_tab [4];
        logic [31:0] ins;
        op_tab[0] = 6'd0; op_tab[1] = 6'd4; op_tab[2] = 6'd5; op_tab[3] = 6'd43;

        // reset for one edge, and it overrides a pending stall
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h100, 32'h0, 32'h1234_5678);
        cyc();
        check("rst PC", bus.PC_Out, 32'h0);
        check("rst Valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
        check("rst StallCount", {16'd0, bus.StallCount}, 32'd0);

        // straight-line fetch
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0022_1820);
        cyc();
        check("fetch PC", bus.PC_Out, 32'h4);
        check("fetch Instr", bus.IF_ID_Instr, 32'h0022_1820);
        check("fetch PC4", bus.IF_ID_PC4, 32'h4);
        check("fetch RS", {27'd0, bus.IF_ID_RS}, 32'd1);
        check("fetch RT", {27'd0, bus.IF_ID_RT}, 32'd2);
        check("fetch RD", {27'd0, bus.IF_ID_RD}, 32'd3);
        check("fetch invalidRt", {31'd0, bus.IF_ID_invalidRt}, 32'd0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h8C00_0000);
        cyc();
        check("lw PC", bus.PC_Out, 32'h8);
        check("lw invalidRt", {31'd0, bus.IF_ID_invalidRt}, 32'd1);

        // load-use stall at PC 8
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h1000_0000);
        cyc();
        check("stall PC", bus.PC_Out, 32'h8);
        check("stall Instr", bus.IF_ID_Instr, 32'h8C00_0000);
        check("stall StallCount", {16'd0, bus.StallCount}, 32'd1);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h1000_0000);
        cyc();

        // taken branch with flush of the wrong-path fetch
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h40, 32'h0, 32'hDEAD_BEEF);
        cyc();
        check("br PC", bus.PC_Out, 32'h40);
        check("br Instr", bus.IF_ID_Instr, 32'h0);
        check("br Valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
        check("br FlushCount", {16'd0, bus.FlushCount}, 32'd1);

        // JR to 0x1000_0000, fetch J there, then take the jump
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h1000_0000, 32'h0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0800_0010);
        cyc();
        check("j setup PC4", bus.IF_ID_PC4, 32'h1000_0004);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0);
        cyc();
        check("jump PC", bus.PC_Out, 32'h1000_0040);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h7, 32'h0000_0020);
        cyc();
        check("jr PC", bus.PC_Out, 32'h4);

        // stall and flush together: IF/ID held, flush not counted
        ins = bus.IF_ID_Instr;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF);
        cyc();
        check("stfl Instr", bus.IF_ID_Instr, ins);
        check("stfl FlushCount", {16'd0, bus.FlushCount}, 32'd3);

        // PC wrap
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'hFFFF_FFFE, 32'h0);
        cyc();
        check("wrap pre PC", bus.PC_Out, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        cyc();
        check("wrap PC", bus.PC_Out, 32'h0);
        check("wrap PC4", bus.IF_ID_PC4, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins = {op_tab[$urandom_range(0, 3)], ins[25:0]};
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)), $urandom, $urandom, ins);
            cyc();
        end

        // stall counter saturation; flushes under stall never counted
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        cyc();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, $urandom);
            cyc();
        end
        check("sat StallCount", {16'd0, bus.StallCount}, 32'h0000_FFFF);
        check("sat FlushCount", {16'd0, bus.FlushCount}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
